// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_if
//  Description : Bundle of the fetch-stage signals shared by the PC
//                generator/queue, instruction memory and the decode stage.
//                Signal names keep their direction suffix relative to the
//                fetch queue itself.
//  Ports       : start_i, imem_addr_o, imem_instr_i, redirect_i,
//                redirect_pc_i, valid_o, ready_i, instr_o, pc4_o, count_o
//  Modports    : slave  - the fetch queue
//                master - the surrounding core (memory, decode, control)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
);
  logic                         start_i;
  logic [ADDR_W-1:0]            imem_addr_o;
  logic [INST_W-1:0]            imem_instr_i;
  logic                         redirect_i;
  logic [ADDR_W-1:0]            redirect_pc_i;
  logic                         valid_o;
  logic                         ready_i;
  logic [INST_W-1:0]            instr_o;
  logic [ADDR_W-1:0]            pc4_o;
  logic [$clog2(DEPTH+1)-1:0]   count_o;

  modport slave (
    input  start_i, imem_instr_i, redirect_i, redirect_pc_i, ready_i,
    output imem_addr_o, valid_o, instr_o, pc4_o, count_o
  );

  modport master (
    output start_i, imem_instr_i, redirect_i, redirect_pc_i, ready_i,
    input  imem_addr_o, valid_o, instr_o, pc4_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction-fetch stage: a PC generator feeding a DEPTH-entry
//                in-order queue of {PC+4, instruction} pairs. Fetch runs ahead
//                of a stalled decode until the queue is full; decode pops the
//                head through valid/ready. A redirect from ID flushes the
//                queue and reloads the PC.
//  Ports       : clk_i  - clock, rising edge
//                rst_i  - asynchronous active-low reset
//                bus    - fetch_queue_if.slave (fetch, memory, decode, redirect)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire                  clk_i,
  input  wire                  rst_i,
  fetch_queue_if.slave         bus
);

  localparam int c_ptr_w   = $clog2(DEPTH);
  localparam int c_cnt_w   = $clog2(DEPTH+1);
  localparam int c_entry_w = ADDR_W + INST_W;
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_1 = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_1 = c_ptr_w'(1);

  logic [ADDR_W-1:0]    r_pc;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_entry_w-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0]    w_pc4;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_deq;
  logic                 w_fetch;
  logic [c_entry_w-1:0] w_head;

  // Wraps naturally modulo 2^ADDR_W.
  assign w_pc4   = r_pc + ADDR_W'(4);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full);
  assign w_deq   = ~w_empty & bus.ready_i;
  // A full queue may still fetch when the head leaves in the same cycle,
  // which keeps throughput unbroken when a stall is released.
  assign w_fetch = bus.start_i & ~bus.redirect_i & (~w_full | w_deq);

  assign w_head          = r_mem[r_rd_ptr];
  assign bus.imem_addr_o = r_pc;
  assign bus.valid_o     = ~w_empty;
  assign bus.instr_o     = w_empty ? '0 : w_head[INST_W-1:0];
  assign bus.pc4_o       = w_empty ? '0 : w_head[c_entry_w-1:INST_W];
  assign bus.count_o     = r_count;

  // Control state. Redirect dominates: same-cycle fetch and dequeue are
  // dropped, so the flushed queue restarts cleanly at the target.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect_i) begin
      r_pc     <= bus.redirect_pc_i;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fetch) begin
        r_pc     <= w_pc4;
        r_wr_ptr <= r_wr_ptr + c_ptr_1;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_1;
      end
      if (w_fetch && !w_deq) begin
        r_count <= r_count + c_cnt_1;
      end else if (w_deq && !w_fetch) begin
        r_count <= r_count - c_cnt_1;
      end
    end
  end

  // Storage is not reset; the gated head outputs hide stale contents.
  always_ff @(posedge clk_i) begin
    if (w_fetch) begin
      r_mem[r_wr_ptr] <= {w_pc4, bus.imem_instr_i};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed self-checking bench for fetch_queue. A reference
//                model holds the expected PC and a scoreboard queue of
//                expected {pc4, instr} entries pushed when a fetch is driven
//                and popped when decode consumes the head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam logic [31:0] c_key = 32'hA5A50000;

  logic clk;
  logic rst;

  fetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // Combinational instruction memory.
  assign bus.imem_instr_i = bus.imem_addr_o ^ c_key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [63:0] sb [$];     // expected {pc4, instr}
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("imem_addr", 64'(bus.imem_addr_o), 64'(m_pc));
    chk("count", 64'(bus.count_o), 64'(sb.size()));
    if (sb.size() != 0) begin
      chk("valid", 64'(bus.valid_o), 64'd1);
      chk("instr", 64'(bus.instr_o), 64'(sb[0][31:0]));
      chk("pc4", 64'(bus.pc4_o), 64'(sb[0][63:32]));
    end else begin
      chk("valid_empty", 64'(bus.valid_o), 64'd0);
      chk("instr_empty", 64'(bus.instr_o), 64'd0);
      chk("pc4_empty", 64'(bus.pc4_o), 64'd0);
    end
  endtask

  // Called at a negedge: check current outputs, drive inputs for the next
  // edge, advance the model, then move to the following negedge.
  task automatic cycle(input bit st, input bit rd, input bit rdr, input logic [31:0] rpc);
    bit deq;
    bit fetch;
    check_outputs();
    bus.start_i       = st;
    bus.ready_i       = rd;
    bus.redirect_i    = rdr;
    bus.redirect_pc_i = rpc;
    if (rdr) begin
      sb.delete();
      m_pc = rpc;
    end else begin
      deq   = (sb.size() != 0) && rd;
      fetch = st && ((sb.size() < DEPTH) || deq);
      if (deq) void'(sb.pop_front());
      if (fetch) begin
        sb.push_back({m_pc + 32'd4, m_pc ^ c_key});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.start_i       = 1'b0;
    bus.ready_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    rst  = 1'b1;
    m_pc = 32'h0;
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_addr", 64'(bus.imem_addr_o), 64'h0);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_instr", 64'(bus.instr_o), 64'd0);
    chk("rst_pc4", 64'(bus.pc4_o), 64'd0);
    chk("rst_count", 64'(bus.count_o), 64'd0);
    rst = 1'b1;

    // Streaming: one instruction per cycle
    cycle(1, 1, 0, 32'h0);
    chk("first_instr", 64'(bus.instr_o), 64'hA5A50000);
    chk("first_pc4", 64'(bus.pc4_o), 64'h4);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 32'h0);
    chk("stream_pc4", 64'(bus.pc4_o), 64'h14);
    chk("stream_count", 64'(bus.count_o), 64'd1);

    // Restart at 0, then stall decode until full
    cycle(1, 1, 1, 32'h0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 32'h0);
    chk("full_count", 64'(bus.count_o), 64'd4);
    chk("full_addr", 64'(bus.imem_addr_o), 64'h10);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc4", 64'(bus.pc4_o), 64'(4 * (i + 1)));
      chk("drain_count", 64'(bus.count_o), 64'd4);
      cycle(1, 1, 0, 32'h0);
    end

    // Redirect from a full queue
    cycle(1, 1, 1, 32'h100);
    chk("redir_count", 64'(bus.count_o), 64'd0);
    chk("redir_valid", 64'(bus.valid_o), 64'd0);
    chk("redir_addr", 64'(bus.imem_addr_o), 64'h100);
    cycle(1, 1, 0, 32'h0);
    chk("redir_instr", 64'(bus.instr_o), 64'hA5A50100);
    chk("redir_pc4", 64'(bus.pc4_o), 64'h104);

    // Build 3 entries, then drain with start low
    cycle(1, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0);
    chk("three_count", 64'(bus.count_o), 64'd3);
    for (int i = 0; i < 4; i++) begin
      chk("nostart_addr", 64'(bus.imem_addr_o), 64'h10C);
      cycle(0, 1, 0, 32'h0);
    end
    chk("nostart_valid", 64'(bus.valid_o), 64'd0);
    chk("nostart_instr", 64'(bus.instr_o), 64'd0);
    chk("nostart_addr_end", 64'(bus.imem_addr_o), 64'h10C);

    // Address wrap
    cycle(1, 1, 1, 32'hFFFFFFFC);
    cycle(1, 1, 0, 32'h0);
    chk("wrap_pc4", 64'(bus.pc4_o), 64'h0);
    chk("wrap_instr", 64'(bus.instr_o), 64'h5A5AFFFC);
    chk("wrap_addr", 64'(bus.imem_addr_o), 64'h0);

    // Back-to-back redirects: only the last target is fetched
    cycle(1, 1, 1, 32'h200);
    cycle(1, 1, 1, 32'h300);
    cycle(1, 1, 0, 32'h0);
    chk("b2b_pc4", 64'(bus.pc4_o), 64'h304);
    chk("b2b_instr", 64'(bus.instr_o), 64'hA5A50300);

    // Asynchronous reset mid-stream with 3 entries queued
    cycle(1, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0);
    check_outputs();
    chk("pre_rst_count", 64'(bus.count_o), 64'd3);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.valid_o), 64'd0);
    chk("arst_instr", 64'(bus.instr_o), 64'd0);
    chk("arst_pc4", 64'(bus.pc4_o), 64'd0);
    chk("arst_count", 64'(bus.count_o), 64'd0);
    chk("arst_addr", 64'(bus.imem_addr_o), 64'h0);
    sb.delete();
    m_pc = 32'h0;
    bus.start_i = 1'b0;
    bus.ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycle(1, 1, 0, 32'h0);
    chk("post_rst_pc4", 64'(bus.pc4_o), 64'h4);
    chk("post_rst_instr", 64'(bus.instr_o), 64'hA5A50000);
    cycle(1, 1, 0, 32'h0);
    cycle(1, 1, 0, 32'h0);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage for the pipelined MIPS core, replacing the PC register, PC+4 adder and single IF/ID latch with a PC generator feeding a DEPTH-entry in-order queue of {PC+4, instruction} pairs. Fetch continues while decode stalls, until the queue is full. The ID stage consumes entries through a valid/ready handshake. Branch and jump resolution in ID drives a single redirect port that flushes the queue and reloads the PC.

## Interface
- ADDR_W, 32: PC/address width; byte addresses, word-aligned.
- INST_W, 32: instruction width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: PC value after reset.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  fetch enable; the PC advances only while high.
- imem_addr_o  out  ADDR_W  current fetch PC to instruction memory (combinational memory; data returns the same cycle).
- imem_instr_i  in  INST_W  instruction at imem_addr_o.
- redirect_i  in  1  taken branch or jump resolved in ID.
- redirect_pc_i  in  ADDR_W  target PC for the redirect.
- valid_o  out  1  queue head holds a valid entry.
- ready_i  in  1  decode accepts the head this cycle; low is a stall (ex IFIDWrite=0).
- instr_o  out  INST_W  head instruction; 0 (NOP) when valid_o=0.
- pc4_o  out  ADDR_W  head PC+4; 0 when valid_o=0.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- State:
  - pc register.
  - DEPTH-entry storage of {pc4, instr}.
  - Read and write pointers, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count register, 0..DEPTH.
- imem_addr_o = pc at all times.
- deq = valid_o & ready_i.
- fetch = start_i & ~redirect_i & (count<DEPTH | deq).
  - Fetching into a full queue is allowed when a dequeue happens in the same cycle.
- On fetch:
  - Write {pc+4, imem_instr_i} at the write pointer.
  - Increment the write pointer.
  - pc ← pc+4, computed modulo 2^ADDR_W (0xFFFFFFFC wraps to 0x00000000).
- On deq: increment the read pointer.
- count update:
  - fetch & ~deq: +1.
  - deq & ~fetch: −1.
  - both: unchanged.
- Redirect (highest priority):
  - pc ← redirect_pc_i.
  - Both pointers ← 0 and count ← 0.
  - Any same-cycle fetch and dequeue are discarded; neither is written or consumed.
  - Redirect is honoured regardless of start_i.
- Head outputs are read combinationally from storage at the read pointer, gated to 0 when count==0.
- start_i low: no fetch and pc holds; the queue continues to drain.
- redirect_pc_i bits [1:0] are not checked; the caller guarantees alignment.
- Storage contents are not reset. Only pc, the pointers and count are reset.

## Timing
- Reset (rst_i low, asynchronous):
  - pc=RESET_PC, imem_addr_o=RESET_PC.
  - valid_o=0, instr_o=0, pc4_o=0, count_o=0.
  - Holds while low. Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- Fetch-to-output latency is 1 cycle: an instruction fetched at edge N is at the head from edge N onward (visible in cycle N+1) if the queue was empty.
- Redirect at edge N:
  - Cycle N+1: imem_addr_o = target, valid_o = 0.
  - Edge N+1: fetches the target.
  - Cycle N+2: valid_o = 1 with the target instruction.
  - Branch penalty is therefore 1 bubble cycle after the redirect cycle.
- Steady state with start_i=1 and ready_i=1: one instruction per cycle, count stays at 1.
- Queue full (count==DEPTH) with ready_i=0: pc holds and imem_addr_o is stable.
  - When ready_i rises, dequeue and fetch happen in the same edge; throughput is unbroken.
- Back-to-back redirects: each one reloads the PC; only the last target is fetched.
- count_o never exceeds DEPTH and never underflows.
  - deq is impossible when count==0 because valid_o=0.

## Test plan
Setup for all scenarios: DEPTH=4, RESET_PC=0, memory returns instr = addr ^ 0xA5A50000.
- Reset then start_i=1, ready_i=1 → cycle after the first edge: valid_o=1, instr_o=0xA5A50000, pc4_o=4; subsequent cycles give pc4_o 8, 12, … with count_o=1 steady.
- ready_i=0 for 8 cycles → count_o reaches 4 after 4 edges, then imem_addr_o holds at 0x10; on releasing ready_i, heads arrive in order with pc4_o 4, 8, 0xC, 0x10 with no gap and no duplicate.
- Full queue, redirect_i=1 with redirect_pc_i=0x100 while ready_i=1 → next cycle: count_o=0, valid_o=0, imem_addr_o=0x100; the cycle after: instr_o=0xA5A50100, pc4_o=0x104.
- start_i=0 with 3 entries queued and ready_i=1 → 3 entries drain, then valid_o=0, instr_o=0; imem_addr_o is unchanged throughout.
- Redirect to 0xFFFFFFFC → pc4_o=0x00000000 for that entry; the next fetch address is 0x00000000.
- Assert rst_i low asynchronously mid-stream, between clock edges, with count_o=3 → outputs are 0 and imem_addr_o=0 immediately; no entry from before the reset appears afterwards.
